// File: rtl/ledger_arbiter_if.sv
// Terminal request/response and external balance-RAM signals of ledger_arbiter.
// The slave modport is the arbiter's view; master is the terminals-plus-RAM side.
interface ledger_arbiter_if;
  logic [1:0]  req_i;
  logic [3:0]  op_i;
  logic [7:0]  index_i;
  logic [7:0]  dest_index_i;
  logic [15:0] amount_i;
  logic [1:0]  done_o;
  logic [1:0]  err_code_o;
  logic [7:0]  balance_value_o;
  logic [3:0]  ram_addr_o;
  logic        ram_we_o;
  logic [7:0]  ram_wdata_o;
  logic [7:0]  ram_rdata_i;
  logic [15:0] txn_count_o;

  modport slave (
    input  req_i, op_i, index_i, dest_index_i, amount_i, ram_rdata_i,
    output done_o, err_code_o, balance_value_o, ram_addr_o, ram_we_o, ram_wdata_o,
           txn_count_o
  );

  modport master (
    output req_i, op_i, index_i, dest_index_i, amount_i, ram_rdata_i,
    input  done_o, err_code_o, balance_value_o, ram_addr_o, ram_we_o, ram_wdata_o,
           txn_count_o
  );
endinterface

// File: rtl/ledger_arbiter.sv
// Two-terminal round-robin arbiter running show/withdraw/deposit/transfer against a 10x8 RAM.
// Define LEDGER_AUDIT_EN to build the committed-transaction counter on txn_count_o.
module ledger_arbiter (
  input  logic            clk,
  input  logic            rst_n,
  ledger_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_SRC, CHK_SRC, RD_DST, CHK_DST, WR_SRC, WR_DST, DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_SHOW     = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_DEPOSIT  = 2'b10,
    OP_TRANSFER = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_BAD_ID   = 2'b01,
    ERR_BALANCE  = 2'b10,
    ERR_TRANSFER = 2'b11
  } err_e;

  typedef struct packed {
    op_e        op;
    logic [3:0] src;
    logic [3:0] dst;
    logic [7:0] amt;
  } txn_t;

  localparam logic [3:0] MAX_ID = 4'd9;

  state_e     state_q, state_d;
  txn_t       txn_q, txn_d;
  logic       gnt_q, gnt_d;          // owner of the current transaction, and last winner
  logic [7:0] src_bal_q, src_bal_d;  // source balance S as read
  logic [7:0] src_new_q, src_new_d;
  logic [7:0] dst_new_q, dst_new_d;
  err_e       err_q, err_d;
  logic [7:0] bal_q, bal_d;

  logic       pick;
  txn_t       cand;
  logic       cand_bad;
  logic [8:0] credit_sum;

  logic [1:0] done;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pick = 1'b0;
    case (bus.req_i)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~gnt_q;
      default: pick = 1'b0;
    endcase
    cand.op  = op_e'(bus.op_i[{pick, 1'b0} +: 2]);
    cand.src = bus.index_i[{pick, 2'b00} +: 4];
    cand.dst = bus.dest_index_i[{pick, 2'b00} +: 4];
    cand.amt = bus.amount_i[{pick, 3'b000} +: 8];
    cand_bad = (cand.src > MAX_ID) || ((cand.op == OP_TRANSFER) && (cand.dst > MAX_ID));
  end

  // Used for the deposit source check and the transfer destination check alike.
  assign credit_sum = {1'b0, bus.ram_rdata_i} + {1'b0, txn_q.amt};

  always_comb begin
    state_d   = state_q;
    txn_d     = txn_q;
    gnt_d     = gnt_q;
    src_bal_d = src_bal_q;
    src_new_d = src_new_q;
    dst_new_d = dst_new_q;
    err_d     = err_q;
    bal_d     = bal_q;
    done      = 2'b00;
    ram_addr  = 4'd0;
    ram_we    = 1'b0;
    ram_wdata = 8'd0;

    case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          gnt_d = pick;
          txn_d = cand;
          if (cand_bad) begin
            err_d   = ERR_BAD_ID;
            bal_d   = 8'd0;
            state_d = DONE;
          end else begin
            state_d = RD_SRC;
          end
        end
      end

      RD_SRC: begin
        ram_addr = txn_q.src;
        state_d  = CHK_SRC;
      end

      CHK_SRC: begin
        src_bal_d = bus.ram_rdata_i;
        case (txn_q.op)
          OP_SHOW: begin
            err_d   = ERR_OK;
            bal_d   = bus.ram_rdata_i;
            state_d = DONE;
          end
          OP_WITHDRAW: begin
            if (txn_q.amt > bus.ram_rdata_i) begin
              err_d   = ERR_BALANCE;
              bal_d   = bus.ram_rdata_i;
              state_d = DONE;
            end else begin
              src_new_d = bus.ram_rdata_i - txn_q.amt;
              state_d   = WR_SRC;
            end
          end
          OP_DEPOSIT: begin
            if (credit_sum[8]) begin
              err_d   = ERR_BALANCE;
              bal_d   = bus.ram_rdata_i;
              state_d = DONE;
            end else begin
              src_new_d = credit_sum[7:0];
              state_d   = WR_SRC;
            end
          end
          OP_TRANSFER: begin
            if (txn_q.dst == txn_q.src) begin
              err_d   = ERR_TRANSFER;
              bal_d   = bus.ram_rdata_i;
              state_d = DONE;
            end else if (txn_q.amt > bus.ram_rdata_i) begin
              err_d   = ERR_BALANCE;
              bal_d   = bus.ram_rdata_i;
              state_d = DONE;
            end else begin
              src_new_d = bus.ram_rdata_i - txn_q.amt;
              state_d   = RD_DST;
            end
          end
          default: state_d = DONE;
        endcase
      end

      RD_DST: begin
        ram_addr = txn_q.dst;
        state_d  = CHK_DST;
      end

      // Nothing has been written yet, so an overflowing credit aborts the whole transfer.
      CHK_DST: begin
        if (credit_sum[8]) begin
          err_d   = ERR_TRANSFER;
          bal_d   = src_bal_q;
          state_d = DONE;
        end else begin
          dst_new_d = credit_sum[7:0];
          state_d   = WR_SRC;
        end
      end

      WR_SRC: begin
        ram_we    = 1'b1;
        ram_addr  = txn_q.src;
        ram_wdata = src_new_q;
        if (txn_q.op == OP_TRANSFER) begin
          state_d = WR_DST;
        end else begin
          err_d   = ERR_OK;
          bal_d   = src_new_q;
          state_d = DONE;
        end
      end

      WR_DST: begin
        ram_we    = 1'b1;
        ram_addr  = txn_q.dst;
        ram_wdata = dst_new_q;
        err_d     = ERR_OK;
        bal_d     = src_new_q;
        state_d   = DONE;
      end

      DONE: begin
        done[gnt_q] = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      txn_q     <= '0;
      gnt_q     <= 1'b1;
      src_bal_q <= 8'd0;
      src_new_q <= 8'd0;
      dst_new_q <= 8'd0;
      err_q     <= ERR_OK;
      bal_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      txn_q     <= txn_d;
      gnt_q     <= gnt_d;
      src_bal_q <= src_bal_d;
      src_new_q <= src_new_d;
      dst_new_q <= dst_new_d;
      err_q     <= err_d;
      bal_q     <= bal_d;
    end
  end

  // Done and the RAM strobes decode the state register, so reset silences them at once.
  assign bus.done_o          = done;
  assign bus.ram_addr_o      = ram_addr;
  assign bus.ram_we_o        = ram_we;
  assign bus.ram_wdata_o     = ram_wdata;
  assign bus.err_code_o      = err_q;
  assign bus.balance_value_o = bal_q;

`ifdef LEDGER_AUDIT_EN
  logic        wrote_q;
  logic [15:0] txn_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrote_q   <= 1'b0;
      txn_cnt_q <= 16'd0;
    end else begin
      if (state_q == WR_SRC) begin
        wrote_q <= 1'b1;
      end else if (state_q == IDLE) begin
        wrote_q <= 1'b0;
      end
      if ((state_q == DONE) && wrote_q) begin
        txn_cnt_q <= txn_cnt_q + 16'd1;
      end
    end
  end

  assign bus.txn_count_o = txn_cnt_q;
`else
  assign bus.txn_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_ledger_arbiter.sv
// Self-checking bench for ledger_arbiter: transaction-level model plus directed vectors
// with hand-computed results; holds the balance RAM with its 1-cycle read latency.
module tb_ledger_arbiter;

  localparam logic [1:0] OP_SHOW     = 2'd0;
  localparam logic [1:0] OP_WITHDRAW = 2'd1;
  localparam logic [1:0] OP_DEPOSIT  = 2'd2;
  localparam logic [1:0] OP_TRANSFER = 2'd3;

  logic clk = 1'b0;
  logic rst_n;

  ledger_arbiter_if bus ();

  ledger_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Balance RAM with a TB-side preload port.
  logic [7:0] ram [16];
  logic       pre_we;
  logic [3:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.ram_we_o) ram[bus.ram_addr_o] <= bus.ram_wdata_o;
    bus.ram_rdata_i <= ram[bus.ram_addr_o];
  end

  // Transaction-level model: outcome, cycles from grant edge to Done, and RAM effects.
  typedef struct packed {
    logic [1:0] err;
    logic [7:0] bal;
    logic [3:0] lat;
    logic [1:0] writes;
    logic [7:0] nsrc;
    logic [7:0] ndst;
  } pred_t;

  function automatic pred_t predict(input logic [1:0] op, input logic [3:0] src,
                                    input logic [3:0] dst, input logic [7:0] amt,
                                    input logic [7:0] s, input logic [7:0] d);
    pred_t p;
    int    sum;
    p     = '0;
    p.bal = s;
    p.lat = 4'd3;
    if (src > 4'd9 || (op == OP_TRANSFER && dst > 4'd9)) begin
      p.err = 2'd1; p.bal = 8'd0; p.lat = 4'd1;
    end else begin
      case (op)
        OP_WITHDRAW: begin
          if (amt > s) p.err = 2'd2;
          else begin p.nsrc = s - amt; p.bal = p.nsrc; p.writes = 2'd1; p.lat = 4'd4; end
        end
        OP_DEPOSIT: begin
          sum = int'(s) + int'(amt);
          if (sum > 255) p.err = 2'd2;
          else begin p.nsrc = 8'(sum); p.bal = p.nsrc; p.writes = 2'd1; p.lat = 4'd4; end
        end
        OP_TRANSFER: begin
          sum = int'(d) + int'(amt);
          if (dst == src) p.err = 2'd3;
          else if (amt > s) p.err = 2'd2;
          else if (sum > 255) begin p.err = 2'd3; p.lat = 4'd5; end
          else begin
            p.nsrc = s - amt; p.ndst = 8'(sum); p.bal = p.nsrc; p.writes = 2'd2; p.lat = 4'd7;
          end
        end
        default: ;
      endcase
    end
    return p;
  endfunction

  logic [7:0]  m_mem [16];
  logic [3:0]  m_cnt;
  logic        m_last, m_t;
  pred_t       m_pend;
  logic [1:0]  m_op;
  logic [3:0]  m_src, m_dst;
  logic [1:0]  m_err_last;
  logic [7:0]  m_bal_last;
  logic [15:0] m_txn;

  logic        m_pick;
  logic [1:0]  m_op_c;
  logic [3:0]  m_src_c, m_dst_c;
  logic [7:0]  m_amt_c;
  pred_t       m_pred;

  assign m_pick  = (bus.req_i == 2'b11) ? ~m_last : bus.req_i[1];
  assign m_op_c  = bus.op_i[{m_pick, 1'b0} +: 2];
  assign m_src_c = bus.index_i[{m_pick, 2'b00} +: 4];
  assign m_dst_c = bus.dest_index_i[{m_pick, 2'b00} +: 4];
  assign m_amt_c = bus.amount_i[{m_pick, 3'b000} +: 8];
  assign m_pred  = predict(m_op_c, m_src_c, m_dst_c, m_amt_c, m_mem[m_src_c], m_mem[m_dst_c]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt      <= 4'd0;
      m_last     <= 1'b1;
      m_t        <= 1'b0;
      m_err_last <= 2'd0;
      m_bal_last <= 8'd0;
      m_txn      <= 16'd0;
    end else begin
      if (pre_we) m_mem[pre_addr] <= pre_data;
      if (m_cnt != 4'd0) begin
        if (m_cnt == 4'd1) begin
          m_err_last <= m_pend.err;
          m_bal_last <= m_pend.bal;
`ifdef LEDGER_AUDIT_EN
          if (m_pend.writes != 2'd0) m_txn <= m_txn + 16'd1;
`endif
        end
        m_cnt <= m_cnt - 4'd1;
      end else if (bus.req_i != 2'b00) begin
        m_last <= m_pick;
        m_t    <= m_pick;
        m_pend <= m_pred;
        m_cnt  <= m_pred.lat;
        m_op   <= m_op_c;
        m_src  <= m_src_c;
        m_dst  <= m_dst_c;
        if (m_pred.writes != 2'd0) m_mem[m_src_c] <= m_pred.nsrc;
        if (m_pred.writes == 2'd2) m_mem[m_dst_c] <= m_pred.ndst;
      end
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  initial begin
    int         wr_cnt;
    logic [1:0] exp_done;
    wr_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_cnt = 0;
        continue;
      end
      if (m_cnt == 4'd0) check("ram_we_idle", 32'(bus.ram_we_o), 32'd0);
      if (bus.ram_we_o) wr_cnt++;
      exp_done = (m_cnt == 4'd1) ? (m_t ? 2'b10 : 2'b01) : 2'b00;
      check("done", 32'(bus.done_o), 32'(exp_done));
      if (m_cnt == 4'd1) begin
        check("err_at_done", 32'(bus.err_code_o), 32'(m_pend.err));
        check("bal_at_done", 32'(bus.balance_value_o), 32'(m_pend.bal));
        check("ram_writes", 32'(wr_cnt), 32'(m_pend.writes));
        if (m_pend.err != 2'd1) begin
          check("ram_src", 32'(ram[m_src]), 32'(m_mem[m_src]));
          if (m_op == OP_TRANSFER) check("ram_dst", 32'(ram[m_dst]), 32'(m_mem[m_dst]));
        end
      end else begin
        check("err_hold", 32'(bus.err_code_o), 32'(m_err_last));
        check("bal_hold", 32'(bus.balance_value_o), 32'(m_bal_last));
      end
      check("txn_count", 32'(bus.txn_count_o), 32'(m_txn));
      if (m_cnt <= 4'd1) wr_cnt = 0;
    end
  end

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic set_fields(input int t, input logic [1:0] op, input logic [3:0] idx,
                            input logic [3:0] dst, input logic [7:0] amt);
    bus.op_i[2*t +: 2]         = op;
    bus.index_i[4*t +: 4]      = idx;
    bus.dest_index_i[4*t +: 4] = dst;
    bus.amount_i[8*t +: 8]     = amt;
  endtask

  // One transaction from terminal t; optionally scrambles its inputs right after the grant.
  task automatic run_txn(input int t, input logic [1:0] op, input logic [3:0] idx,
                         input logic [3:0] dst, input logic [7:0] amt, input int exp_lat,
                         input logic [1:0] exp_err, input logic [7:0] exp_bal, input bit scramble);
    int cyc;
    cyc = 0;
    @(negedge clk);
    set_fields(t, op, idx, dst, amt);
    bus.req_i[t] = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (scramble && cyc == 1) set_fields(t, OP_WITHDRAW, 4'd0, 4'd0, 8'hFF);
    end while (!bus.done_o[t] && cyc < 20);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("err", 32'(bus.err_code_o), 32'(exp_err));
    check("bal", 32'(bus.balance_value_o), 32'(exp_bal));
    bus.req_i[t] = 1'b0;
  endtask

  initial begin
    int         seq [4];
    int         n;
    int         cyc;
    logic [7:0] init_bal [10];

    rst_n = 1'b0;
    bus.req_i = 2'b00; bus.op_i = '0; bus.index_i = '0; bus.dest_index_i = '0; bus.amount_i = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_err", 32'(bus.err_code_o), 32'd0);
    check("rst_bal", 32'(bus.balance_value_o), 32'd0);
    check("rst_we", 32'(bus.ram_we_o), 32'd0);
    check("rst_addr", 32'(bus.ram_addr_o), 32'd0);
    check("rst_wdata", 32'(bus.ram_wdata_o), 32'd0);
    check("rst_txn", 32'(bus.txn_count_o), 32'd0);
    #2 rst_n = 1'b1;

    init_bal = '{8'd0, 8'd200, 8'd50, 8'd100, 8'd250, 8'd10, 8'd250, 8'd80, 8'd20, 8'd0};
    for (int i = 0; i < 10; i++) preload(4'(i), init_bal[i]);

    // Both terminals request continuously: grants alternate starting with terminal 0.
    @(negedge clk);
    set_fields(0, OP_SHOW, 4'd3, 4'd0, 8'd0);
    set_fields(1, OP_SHOW, 4'd5, 4'd0, 8'd0);
    bus.req_i = 2'b11;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done_o[0]) begin seq[n] = 0; n++; end
      else if (bus.done_o[1]) begin seq[n] = 1; n++; end
      if (n == 4) bus.req_i = 2'b00;
    end
    bus.req_i = 2'b00;
    check("rr_count", 32'(n), 32'd4);
    check("rr_0", 32'(seq[0]), 32'd0);
    check("rr_1", 32'(seq[1]), 32'd1);
    check("rr_2", 32'(seq[2]), 32'd0);
    check("rr_3", 32'(seq[3]), 32'd1);

    run_txn(0, OP_SHOW, 4'd3, 4'd0, 8'd0, 3, 2'd0, 8'd100, 1'b0);
    run_txn(1, OP_WITHDRAW, 4'd2, 4'd0, 8'd60, 3, 2'd2, 8'd50, 1'b0);
    check("ram2_kept", 32'(ram[2]), 32'd50);
    run_txn(1, OP_WITHDRAW, 4'd2, 4'd0, 8'd50, 4, 2'd0, 8'd0, 1'b0);
    check("ram2_zero", 32'(ram[2]), 32'd0);
    run_txn(0, OP_TRANSFER, 4'd1, 4'd4, 8'd10, 5, 2'd3, 8'd200, 1'b0);
    check("ram1_kept", 32'(ram[1]), 32'd200);
    check("ram4_kept", 32'(ram[4]), 32'd250);
    run_txn(0, OP_TRANSFER, 4'd1, 4'd4, 8'd5, 7, 2'd0, 8'd195, 1'b0);
    check("ram1_xfer", 32'(ram[1]), 32'd195);
    check("ram4_xfer", 32'(ram[4]), 32'd255);
    run_txn(1, OP_TRANSFER, 4'd1, 4'd1, 8'd0, 3, 2'd3, 8'd195, 1'b0);
    run_txn(1, OP_TRANSFER, 4'd5, 4'd6, 8'd20, 3, 2'd2, 8'd10, 1'b0);
    run_txn(0, OP_SHOW, 4'd12, 4'd0, 8'd0, 1, 2'd1, 8'd0, 1'b0);
    run_txn(0, OP_TRANSFER, 4'd3, 4'd10, 8'd1, 1, 2'd1, 8'd0, 1'b0);
    run_txn(1, OP_DEPOSIT, 4'd6, 4'd0, 8'd10, 3, 2'd2, 8'd250, 1'b0);
    run_txn(1, OP_DEPOSIT, 4'd6, 4'd0, 8'd5, 4, 2'd0, 8'd255, 1'b0);
    check("ram6_full", 32'(ram[6]), 32'd255);
    run_txn(0, OP_DEPOSIT, 4'd5, 4'd0, 8'd5, 4, 2'd0, 8'd15, 1'b1);
    check("ram5_latched", 32'(ram[5]), 32'd15);

    // Reset during WR_DST of a 30-unit transfer 7 -> 8.
    @(negedge clk);
    set_fields(0, OP_TRANSFER, 4'd7, 4'd8, 8'd30);
    bus.req_i[0] = 1'b1;
    for (int c = 0; c < 6; c++) @(negedge clk);
    check("wrdst_we", 32'(bus.ram_we_o), 32'd1);
    check("wrdst_addr", 32'(bus.ram_addr_o), 32'd8);
    check("wrdst_data", 32'(bus.ram_wdata_o), 32'd50);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we", 32'(bus.ram_we_o), 32'd0);
    check("abort_addr", 32'(bus.ram_addr_o), 32'd0);
    check("abort_done", 32'(bus.done_o), 32'd0);
    bus.req_i = 2'b00;
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("abort_src", 32'(ram[7]), 32'd50);
    check("abort_dst", 32'(ram[8]), 32'd20);
    preload(4'd8, 8'd20);

    // Three committed deposits and one rejected withdraw on account 9.
    run_txn(0, OP_DEPOSIT, 4'd9, 4'd0, 8'd10, 4, 2'd0, 8'd10, 1'b0);
    run_txn(1, OP_DEPOSIT, 4'd9, 4'd0, 8'd20, 4, 2'd0, 8'd30, 1'b0);
    run_txn(0, OP_DEPOSIT, 4'd9, 4'd0, 8'd30, 4, 2'd0, 8'd60, 1'b0);
    run_txn(1, OP_WITHDRAW, 4'd9, 4'd0, 8'd100, 3, 2'd2, 8'd60, 1'b0);
    @(negedge clk);
`ifdef LEDGER_AUDIT_EN
    check("txn_final", 32'(bus.txn_count_o), 32'd3);
`else
    check("txn_final", 32'(bus.txn_count_o), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
